// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the shift-add MUL sequencer: default widths, ALU
// control codes and the sequencer state encoding.
package mul_sequencer_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_MUL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_SLTU = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier.
// load_i captures fresh operands; step_i performs one iteration.
module mul_shift_add_dp #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic [XLEN-1:0] acc_o
);

  logic [XLEN-1:0] acc_q,   acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplr_q,  mplr_d;

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    if (load_i) begin
      acc_d   = '0;
      mcand_d = rs1_data_i;
      mplr_d  = rs2_data_i;
    end else if (step_i) begin
      // Sum wraps naturally: only the low XLEN product bits are kept.
      if (mplr_q[0]) acc_d = acc_q + mcand_q;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle RV32 MUL sequencer: stalls the pipeline for XLEN+1 cycles and
// then flags the low product bits valid for one cycle.
//   state | meaning
//   IDLE  | waiting for a MUL in EX; start loads operands
//   BUSY  | one shift-add iteration per cycle, XLEN iterations
//   DONE  | result_o valid for one cycle, pipeline released
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [3:0]      ALUCtrl_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             start;
  logic             load;
  logic             step;

  assign start = valid_i & (ALUCtrl_i == ALU_MUL) & ~flush_i;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    load           = 1'b0;
    step           = 1'b0;
    stall_o        = 1'b0;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          stall_o = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        // A flush releases the pipeline in the same cycle it is seen.
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          step    = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = DONE;
        end
      end
      DONE: begin
        result_valid_o = ~flush_i;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mul_shift_add_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .acc_o      (result_o)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: vector table, scoreboard of expected
// products, and hand-written flush / reset / back-to-back sequences.
module tb_mul_sequencer;

  localparam logic [3:0] MUL = 4'b0101;
  localparam logic [3:0] ADD = 4'b0010;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  ALUCtrl_i = 4'b0;
  logic        flush_i = 1'b0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        stall_o;
  logic        busy_o;
  logic [31:0] result_o;
  logic        result_valid_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mul_sequencer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .ALUCtrl_i      (ALUCtrl_i),
    .flush_i        (flush_i),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    bit          v;
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    bit          fl;
    bit          exp_start;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] alu, input logic [31:0] a,
                       input logic [31:0] b, input bit fl);
    valid_i    = v;
    ALUCtrl_i  = alu;
    rs1_data_i = a;
    rs2_data_i = b;
    flush_i    = fl;
  endtask

  // Scoreboard: every result_valid_o pulse must match the oldest pending product.
  always @(negedge clk_i) begin
    if (!rst_i && result_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("result", result_o, e);
      end
    end
  end

  // Full MUL from start cycle T to DONE at T+33; optionally presents the next
  // MUL during DONE, which must be ignored until the following cycle.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b,
                        input bit chain, input logic [31:0] na, input logic [31:0] nb);
    logic [31:0] p;
    p = a * b;
    drive(1'b1, MUL, a, b, 1'b0);
    exp_q.push_back(p);
    @(negedge clk_i);
    chk("stall_start", {31'd0, stall_o}, 32'd1);
    chk("busy_start", {31'd0, busy_o}, 32'd0);
    tick();
    drive(1'b0, ADD, ~a, ~b, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk_i);
      chk($sformatf("stall_busy_%0d", k), {31'd0, stall_o}, 32'd1);
      chk($sformatf("busy_%0d", k), {31'd0, busy_o}, 32'd1);
      chk($sformatf("rvalid_busy_%0d", k), {31'd0, result_valid_o}, 32'd0);
      tick();
    end
    if (chain) drive(1'b1, MUL, na, nb, 1'b0);
    @(negedge clk_i);
    chk("stall_done", {31'd0, stall_o}, 32'd0);
    chk("busy_done", {31'd0, busy_o}, 32'd0);
    chk("rvalid_done", {31'd0, result_valid_o}, 32'd1);
    chk("result_done", result_o, p);
    tick();
    if (!chain) drive(1'b0, 4'b0, '0, '0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{"mul_3x5",       1'b1, MUL, 32'd3,         32'd5,         1'b0, 1'b1};
    vecs[1] = '{"mul_ffff_x2",   1'b1, MUL, 32'hFFFF_FFFF, 32'd2,         1'b0, 1'b1};
    vecs[2] = '{"mul_wrap",      1'b1, MUL, 32'h8000_0000, 32'd2,         1'b0, 1'b1};
    vecs[3] = '{"mul_zero",      1'b1, MUL, 32'd0,         32'h0001_2345, 1'b0, 1'b1};
    vecs[4] = '{"mul_mixed",     1'b1, MUL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1};
    vecs[5] = '{"add_valid",     1'b1, ADD, 32'd7,         32'd9,         1'b0, 1'b0};
    vecs[6] = '{"mul_not_valid", 1'b0, MUL, 32'd7,         32'd9,         1'b0, 1'b0};
    vecs[7] = '{"mul_flushed",   1'b1, MUL, 32'd7,         32'd9,         1'b1, 1'b0};

    #1 rst_i = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_rvalid", {31'd0, result_valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].exp_start) begin
        mul_op(vecs[i].a, vecs[i].b, 1'b0, '0, '0);
      end else begin
        drive(vecs[i].v, vecs[i].alu, vecs[i].a, vecs[i].b, vecs[i].fl);
        @(negedge clk_i);
        chk({vecs[i].name, "_stall"}, {31'd0, stall_o}, 32'd0);
        tick();
        drive(1'b0, 4'b0, '0, '0, 1'b0);
        @(negedge clk_i);
        chk({vecs[i].name, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({vecs[i].name, "_stall2"}, {31'd0, stall_o}, 32'd0);
        tick();
      end
    end

    // Flush at T+10: released immediately, no result, new start at T+12.
    drive(1'b1, MUL, 32'd11, 32'd13, 1'b0);
    exp_q.push_back(32'd143);
    tick();
    drive(1'b0, 4'b0, '0, '0, 1'b0);
    for (int k = 0; k < 9; k++) tick();
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_busy", {31'd0, busy_o}, 32'd1);
    void'(exp_q.pop_back());
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("post_flush_busy", {31'd0, busy_o}, 32'd0);
    chk("post_flush_stall", {31'd0, stall_o}, 32'd0);
    tick();
    mul_op(32'd21, 32'd4, 1'b0, '0, '0);

    // Asynchronous reset at T+5 mid-cycle.
    drive(1'b1, MUL, 32'd100, 32'd100, 1'b0);
    exp_q.push_back(32'd10000);
    tick();
    drive(1'b0, 4'b0, '0, '0, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_rvalid", {31'd0, result_valid_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    void'(exp_q.pop_back());
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    tick();
    mul_op(32'd7, 32'd6, 1'b0, '0, '0);

    // Back-to-back: second MUL sits in EX during DONE.
    mul_op(32'd6, 32'd7, 1'b1, 32'd9, 32'd9);
    mul_op(32'd9, 32'd9, 1'b0, '0, '0);

    for (int k = 0; k < 3; k++) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
